// File: rtl/led_mode_scheduler.sv
// led_mode_scheduler: button debounce, step-rate tick generation and
// manual/auto sequencing of the running-LED pattern mode index.

// Two-flop synchronizer cell with a selectable reset level.
module led_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    if (reset) ff <= {2{RST_VAL}};
    else       ff <= {ff[0], d};
  end

  assign q = ff[1];
endmodule

module led_mode_scheduler #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_MODES       = 8,
  parameter int DWELL_TICKS     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       auto,
  input  logic [2:0] mode_hz,
  output logic       tick,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       btn_pulse,
  output logic       out_auto
);
  localparam int NUM_SYNC = 2;
  localparam int SYNC_KEY = 0;
  localparam int SYNC_AUTO = 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ + 1) : 1;
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);
  localparam logic [2:0]      MODE_LAST  = 3'(NUM_MODES - 1);

  typedef enum logic {S_MANUAL, S_AUTO} state_t;

  // Per-input synchronizers: key idles released (1), auto idles off (0).
  logic [NUM_SYNC-1:0] sync_d, sync_q;
  logic                key_s, auto_s;

  assign sync_d[SYNC_KEY]  = key_n;
  assign sync_d[SYNC_AUTO] = auto;

  for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
    led_sync2 #(.RST_VAL((i == SYNC_KEY) ? 1'b1 : 1'b0)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (sync_d[i]),
      .q    (sync_q[i])
    );
  end

  assign key_s  = sync_q[SYNC_KEY];
  assign auto_s = sync_q[SYNC_AUTO];

  // Debounce: accept a new key level only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; pulse on the press edge.
  logic            deb;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      deb       <= 1'b1;
      db_cnt    <= '0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      if (key_s == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb       <= key_s;
        db_cnt    <= '0;
        btn_pulse <= ~key_s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Divider limit follows mode_hz combinationally so a rate change
  // is seen on the very next edge; a zero span means tick every cycle.
  logic [31:0] div_span, div_lim;
  logic [DIV_W-1:0] div_cnt;

  always_comb begin
    div_span = 32'(CLK_HZ) >> mode_hz;
    div_lim  = '0;
    if (div_span != '0) div_lim = div_span - 32'd1;
  end

  // Step-rate divider; >= (not ==) catches a count left above a new,
  // smaller limit and fires on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (32'(div_cnt) >= div_lim) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  // Mode sequencing FSM. A press always advances and restarts the dwell,
  // so a press landing on dwell expiry still yields a single step.
  state_t          state;
  logic [DW_W-1:0] dwell_cnt;
  logic [2:0]      mode_nxt;

  assign mode_nxt = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_MANUAL;
      out_auto  <= 1'b0;
      mode      <= '0;
      mode_chg  <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      mode_chg <= 1'b0;
      case (state)
        S_MANUAL: begin
          if (btn_pulse) begin
            mode     <= mode_nxt;
            mode_chg <= 1'b1;
          end
          if (auto_s) begin
            state     <= S_AUTO;
            out_auto  <= 1'b1;
            dwell_cnt <= '0;
          end
        end
        S_AUTO: begin
          if (btn_pulse) begin
            mode      <= mode_nxt;
            mode_chg  <= 1'b1;
            dwell_cnt <= '0;
          end else if (auto_s && tick) begin
            if (dwell_cnt == DWELL_LAST) begin
              mode      <= mode_nxt;
              mode_chg  <= 1'b1;
              dwell_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DW_W'(1);
            end
          end
          if (!auto_s) begin
            state    <= S_MANUAL;
            out_auto <= 1'b0;
          end
        end
        default: begin
          state    <= S_MANUAL;
          out_auto <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_mode_scheduler.sv
module tb_led_mode_scheduler;
  logic       clk;
  logic       reset;
  logic       key_n;
  logic       auto;
  logic [2:0] mode_hz;
  logic       tick;
  logic [2:0] mode;
  logic       mode_chg;
  logic       btn_pulse;
  logic       out_auto;

  int n_assert = 0;
  int n_fail   = 0;
  int n_btn    = 0;
  int n_chg    = 0;
  int b0, c0;
  logic [2:0] exp_mode;

  led_mode_scheduler #(
    .CLK_HZ(64), .DEBOUNCE_CYCLES(4), .NUM_MODES(8), .DWELL_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .auto(auto), .mode_hz(mode_hz),
    .tick(tick), .mode(mode), .mode_chg(mode_chg), .btn_pulse(btn_pulse),
    .out_auto(out_auto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_pulse) n_btn++;
    if (mode_chg)  n_chg++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    key_n = 1'b0;
    step(8);
    key_n = 1'b1;
    step(8);
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b0; auto = 1'b1; mode_hz = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_mode", mode, 3'd0);
      chk("rst_tick", tick, 1'b0);
      chk("rst_chg", mode_chg, 1'b0);
      chk("rst_btn", btn_pulse, 1'b0);
      chk("rst_auto", out_auto, 1'b0);
    end
    reset = 1'b0; key_n = 1'b1; auto = 1'b0;

    step(63); chk("tick0_e63", tick, 1'b0);
    step(1);  chk("tick0_e64", tick, 1'b1);
    step(1);  chk("tick0_e65", tick, 1'b0);
    step(62); chk("tick0_e127", tick, 1'b0);
    step(1);  chk("tick0_e128", tick, 1'b1);
    step(20); chk("tick_pre_sw", tick, 1'b0);
    mode_hz = 3'd3;
    step(1);  chk("tick_sw_now", tick, 1'b1);
    step(1);  chk("tick3_e1", tick, 1'b0);
    step(6);  chk("tick3_e7", tick, 1'b0);
    step(1);  chk("tick3_e8", tick, 1'b1);
    mode_hz = 3'd7;
    step(1);  chk("tick7_a", tick, 1'b1);
    step(1);  chk("tick7_b", tick, 1'b1);
    step(1);  chk("tick7_c", tick, 1'b1);

    b0 = n_btn; c0 = n_chg;
    key_n = 1'b0; step(3); key_n = 1'b1; step(10);
    chk("glitch_btn", n_btn - b0, 0);
    chk("glitch_chg", n_chg - c0, 0);
    chk("glitch_mode", mode, 3'd0);

    b0 = n_btn; c0 = n_chg;
    key_n = 1'b0;
    step(5); chk("press_btn_e5", btn_pulse, 1'b0);
    step(1); chk("press_btn_e6", btn_pulse, 1'b1);
             chk("press_mode_e6", mode, 3'd0);
    step(1); chk("press_btn_e7", btn_pulse, 1'b0);
             chk("press_mode_e7", mode, 3'd1);
             chk("press_chg_e7", mode_chg, 1'b1);
    step(1); chk("press_chg_e8", mode_chg, 1'b0);
    step(2);
    key_n = 1'b1; step(12);
    chk("press_btn_cnt", n_btn - b0, 1);
    chk("press_chg_cnt", n_chg - c0, 1);
    chk("press_mode_end", mode, 3'd1);

    exp_mode = 3'd1;
    for (int i = 0; i < 7; i++) begin
      press();
      exp_mode = (exp_mode == 3'd7) ? 3'd0 : exp_mode + 3'd1;
    end
    chk("wrap_start", mode, exp_mode);
    b0 = n_btn; c0 = n_chg;
    for (int i = 0; i < 8; i++) begin
      press();
      exp_mode = (exp_mode == 3'd7) ? 3'd0 : exp_mode + 3'd1;
      chk("wrap_mode", mode, exp_mode);
    end
    chk("wrap_end_zero", mode, 3'd0);
    chk("wrap_btn_cnt", n_btn - b0, 8);
    chk("wrap_chg_cnt", n_chg - c0, 8);

    mode_hz = 3'd3; auto = 1'b1;
    step(2);  chk("auto_e2", out_auto, 1'b0);
    step(1);  chk("auto_e3", out_auto, 1'b1);
    step(21); chk("auto_e24_mode", mode, 3'd0);
    step(1);  chk("auto_e25_mode", mode, 3'd1);
              chk("auto_e25_chg", mode_chg, 1'b1);
    step(1);  chk("auto_e26_chg", mode_chg, 1'b0);
    step(22); chk("auto_e48_mode", mode, 3'd1);
    step(1);  chk("auto_e49_mode", mode, 3'd2);
    step(5);  key_n = 1'b0;
    step(6);  chk("ovr_e60_btn", btn_pulse, 1'b1);
              chk("ovr_e60_mode", mode, 3'd2);
    step(1);  chk("ovr_e61_mode", mode, 3'd3);
              chk("ovr_e61_chg", mode_chg, 1'b1);
    key_n = 1'b1;
    step(12); chk("ovr_e73_mode", mode, 3'd3);
    step(7);  chk("ovr_e80_mode", mode, 3'd3);
    step(1);  chk("ovr_e81_mode", mode, 3'd4);
              chk("ovr_e81_chg", mode_chg, 1'b1);
    step(17); c0 = n_chg; key_n = 1'b0;
    step(6);  chk("sim_e104_btn", btn_pulse, 1'b1);
              chk("sim_e104_tick", tick, 1'b1);
              chk("sim_e104_mode", mode, 3'd4);
    step(1);  chk("sim_e105_mode", mode, 3'd5);
              chk("sim_e105_chg", mode_chg, 1'b1);
    step(1);  chk("sim_e106_chg", mode_chg, 1'b0);
    key_n = 1'b1;
    step(22); chk("sim_e128_mode", mode, 3'd5);
              chk("sim_chg_cnt", n_chg - c0, 1);

    reset = 1'b1;
    step(1);  chk("mid_rst_mode", mode, 3'd0);
              chk("mid_rst_auto", out_auto, 1'b0);
              chk("mid_rst_tick", tick, 1'b0);
              chk("mid_rst_chg", mode_chg, 1'b0);
    step(1);
    reset = 1'b0;
    step(2);  chk("rel_e2_auto", out_auto, 1'b0);
    step(1);  chk("rel_e3_auto", out_auto, 1'b1);
    step(21); chk("rel_e24_mode", mode, 3'd0);
    step(1);  chk("rel_e25_mode", mode, 3'd1);
              chk("rel_e25_chg", mode_chg, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
